dtcm_ctrl_pipe: RTL

Parametrised DTCM controller between the LSU command/response channel and a synchronous single-port DTCM SRAM with one-cycle read latency. Accepts one command per cycle under valid/ready and returns exactly one response per command, in order, with read data or write acknowledge. Responses are buffered so the LSU may stall them. Misaligned and out-of-range accesses are blocked from the RAM and flagged with an error.

---
 rtl/dtcm_ctrl_pipe_pkg.sv | 22 ++
 rtl/dtcm_rsp_fifo.sv | 51 +++++
 rtl/dtcm_ctrl_pipe.sv | 106 ++++++++++
 3 files changed

// File: rtl/dtcm_ctrl_pipe_pkg.sv
// Shared defaults and payload layout for the DTCM controller.
// Optional response bypass is enabled by defining DTCM_CTRL_RSP_BYPASS_EN at build time.
package dtcm_ctrl_pipe_pkg;

  localparam int unsigned DTCM_ADDR_WIDTH = 16;
  localparam int unsigned DTCM_RAM_DW     = 32;
  localparam int unsigned DTCM_RAM_MW     = DTCM_RAM_DW / 8;
  localparam int unsigned DTCM_RAM_AW     = 12;

  // Command attributes carried alongside the one-cycle RAM read.
  typedef struct packed {
    logic valid;
    logic read;
    logic err;
  } s1_t;

  // Response entry is packed as {err, rdata}.
  function automatic int unsigned rsp_entry_w(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/dtcm_rsp_fifo.sv
// Response FIFO with modulo-DEPTH pointers and an occupancy count.
module dtcm_rsp_fifo #(
  parameter  int unsigned W     = 33,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dtcm_ctrl_pipe.sv
// LSU-to-DTCM controller: address check, RAM drive, in-order buffered responses.
// Define DTCM_CTRL_RSP_BYPASS_EN to forward the stage-1 response when the FIFO is empty.
module dtcm_ctrl_pipe
  import dtcm_ctrl_pipe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DTCM_ADDR_WIDTH,
  parameter int unsigned DW         = DTCM_RAM_DW,
  parameter int unsigned MW         = DW / 8,
  parameter int unsigned RAM_DEPTH  = 2 ** DTCM_RAM_AW,
  parameter int unsigned RAM_AW     = $clog2(RAM_DEPTH),
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu2dtcm_cmd_valid,
  output logic                  lsu2dtcm_cmd_ready,
  input  logic                  lsu2dtcm_cmd_read,
  input  logic [ADDR_WIDTH-1:0] lsu2dtcm_cmd_addr,
  input  logic [MW-1:0]         lsu2dtcm_cmd_wmask,
  input  logic [DW-1:0]         lsu2dtcm_cmd_wdata,
  output logic                  lsu2dtcm_rsp_valid,
  input  logic                  lsu2dtcm_rsp_ready,
  output logic [DW-1:0]         lsu2dtcm_rsp_rdata,
  output logic                  lsu2dtcm_rsp_err,
  output logic                  dtcm_ram_cs,
  output logic                  dtcm_ram_we,
  output logic [RAM_AW-1:0]     dtcm_ram_addr,
  output logic [MW-1:0]         dtcm_ram_wem,
  output logic [DW-1:0]         dtcm_ram_din,
  input  logic [DW-1:0]         dtcm_ram_dout
);

  localparam int unsigned OFF = $clog2(MW);
  localparam int unsigned IW  = ADDR_WIDTH - OFF;
  localparam int unsigned EW  = rsp_entry_w(DW);
  localparam int unsigned CW  = $clog2(RSP_DEPTH) + 1;
  localparam logic [IW:0] DEPTH_EXT = (IW + 1)'(RAM_DEPTH);

  logic          acc;
  logic          err;
  logic [IW-1:0] widx;
  s1_t           s1;
  logic [EW-1:0] s1_entry;
  logic [EW-1:0] head;
  logic [EW-1:0] rsp_sel;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  assign widx = lsu2dtcm_cmd_addr[ADDR_WIDTH-1:OFF];
  assign err  = (lsu2dtcm_cmd_addr[OFF-1:0] != '0) || ({1'b0, widx} >= DEPTH_EXT);

  // Credit check counts the response still in stage 1, so the FIFO cannot overflow.
  assign lsu2dtcm_cmd_ready = !full && ((32'(count) + 32'(s1.valid)) < RSP_DEPTH);
  assign acc = lsu2dtcm_cmd_valid && lsu2dtcm_cmd_ready && !rst;

  assign dtcm_ram_cs   = acc && !err;
  assign dtcm_ram_we   = dtcm_ram_cs && !lsu2dtcm_cmd_read;
  assign dtcm_ram_addr = widx[RAM_AW-1:0];
  assign dtcm_ram_wem  = dtcm_ram_cs ? lsu2dtcm_cmd_wmask : '0;
  assign dtcm_ram_din  = lsu2dtcm_cmd_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= acc;
      s1.read  <= lsu2dtcm_cmd_read;
      s1.err   <= err;
    end
  end

  assign s1_entry = {s1.err, (s1.read && !s1.err) ? dtcm_ram_dout : DW'(0)};

`ifdef DTCM_CTRL_RSP_BYPASS_EN
  // Forwarded response is only buffered if the LSU does not take it immediately.
  assign push               = s1.valid && !(empty && lsu2dtcm_rsp_ready);
  assign lsu2dtcm_rsp_valid = !empty || s1.valid;
  assign rsp_sel            = !empty ? head : (s1.valid ? s1_entry : '0);
`else
  assign push               = s1.valid;
  assign lsu2dtcm_rsp_valid = !empty;
  assign rsp_sel            = !empty ? head : '0;
`endif

  assign pop = !empty && lsu2dtcm_rsp_ready;
  assign {lsu2dtcm_rsp_err, lsu2dtcm_rsp_rdata} = rsp_sel;

  dtcm_rsp_fifo #(
    .W     (EW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (s1_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule
